usb_xfer_ctrl: RTL and testbench



---
 rtl/usb_xfer_ctrl.sv | 256 +++++++++++++++++++++++++
 tb/tb_usb_xfer_ctrl.sv | 441 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_xfer_ctrl.sv
// usb_xfer_ctrl
// Device-side USB transaction sequencer sitting above the token/packet layer.
// Decodes OUT/SETUP/IN tokens addressed to this device, runs the data and
// handshake phases, keeps per-endpoint DATA0/DATA1 toggles and decides which
// handshake (ACK/NAK/STALL) to request from the packet layer.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   dev_addr                 assigned device address
//   rx_*_token, rx_addr,
//   rx_endpoint              token strobes and their address/endpoint
//   rx_ack                   host ACK strobe
//   rx_data_type/_end/_error received data PID, end strobe and CRC error
//   ep_out_ready, ep_in_ready, ep_stall   per-endpoint buffer status
//   tx_ack/tx_nack/tx_stall  handshake request pulses
//   out_ep, out_active       endpoint receiving OUT/SETUP data, phase flag
//   out_commit/out_discard   keep / drop the received packet
//   setup_seen               valid SETUP packet committed
//   in_ep, in_start, in_toggle  IN data source select, start pulse, PID
//   in_done                  IN data packet fully transmitted
//   in_acked/in_timeout      IN packet acknowledged / abandoned
//   All outputs are registered: a strobe at cycle T is answered at T+1.

module usb_xfer_ctrl #(
    parameter int NUM_EP     = 4,
    parameter int HS_TIMEOUT = 800
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [6:0]        dev_addr,
    input  logic              rx_in_token,
    input  logic              rx_out_token,
    input  logic              rx_setup_token,
    input  logic [6:0]        rx_addr,
    input  logic [3:0]        rx_endpoint,
    input  logic              rx_ack,
    input  logic [1:0]        rx_data_type,
    input  logic              rx_data_end,
    input  logic              rx_data_error,
    input  logic [NUM_EP-1:0] ep_out_ready,
    input  logic [NUM_EP-1:0] ep_in_ready,
    input  logic [NUM_EP-1:0] ep_stall,
    output logic              tx_ack,
    output logic              tx_nack,
    output logic              tx_stall,
    output logic [3:0]        out_ep,
    output logic              out_active,
    output logic              out_commit,
    output logic              out_discard,
    output logic              setup_seen,
    output logic [3:0]        in_ep,
    output logic              in_start,
    output logic              in_toggle,
    input  logic              in_done,
    output logic              in_acked,
    output logic              in_timeout
);

    localparam int CW = $clog2(HS_TIMEOUT + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(HS_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        OUT_DATA,
        SETUP_DATA,
        IN_DATA,
        IN_WAIT_ACK
    } state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [15:0]   out_tog, out_tog_nx, in_tog, in_tog_nx;
    logic [3:0]    out_ep_nx, in_ep_nx;
    logic          in_toggle_nx, out_active_nx;
    logic          tx_ack_nx, tx_nack_nx, tx_stall_nx;
    logic          out_commit_nx, out_discard_nx, setup_seen_nx;
    logic          in_start_nx, in_acked_nx, in_timeout_nx;

    // Endpoint status widened to 16 bits so a 4-bit endpoint number can
    // index it directly for any NUM_EP.
    logic [15:0] out_rdy_w, in_rdy_w, stall_w;
    assign out_rdy_w = 16'(ep_out_ready);
    assign in_rdy_w  = 16'(ep_in_ready);
    assign stall_w   = 16'(ep_stall);

    logic token_any, token_hit, timed_out;
    assign token_any = rx_in_token | rx_out_token | rx_setup_token;
    assign token_hit = token_any && (rx_addr == dev_addr) &&
                       (32'(rx_endpoint) < NUM_EP);
    // Last waiting cycle: the counter holds the number of cycles already
    // spent in the state, so HS_TIMEOUT cycles have elapsed at TO_LAST.
    assign timed_out = (cnt == TO_LAST);

    // Next-state, toggle and response decode. Any token arriving during a
    // data or ACK wait aborts the transaction exactly like a timeout, and
    // that token is dropped rather than started.
    always_comb begin
        state_nx       = state;
        cnt_nx         = '0;
        out_tog_nx     = out_tog;
        in_tog_nx      = in_tog;
        out_ep_nx      = out_ep;
        in_ep_nx       = in_ep;
        in_toggle_nx   = in_toggle;
        tx_ack_nx      = 1'b0;
        tx_nack_nx     = 1'b0;
        tx_stall_nx    = 1'b0;
        out_commit_nx  = 1'b0;
        out_discard_nx = 1'b0;
        setup_seen_nx  = 1'b0;
        in_start_nx    = 1'b0;
        in_acked_nx    = 1'b0;
        in_timeout_nx  = 1'b0;

        case (state)
            IDLE: begin
                if (token_hit) begin
                    if (rx_setup_token) begin
                        out_ep_nx = rx_endpoint;
                        state_nx  = SETUP_DATA;
                    end else if (rx_out_token) begin
                        out_ep_nx = rx_endpoint;
                        state_nx  = OUT_DATA;
                    end else if (stall_w[rx_endpoint]) begin
                        tx_stall_nx = 1'b1;
                    end else if (!in_rdy_w[rx_endpoint]) begin
                        tx_nack_nx = 1'b1;
                    end else begin
                        in_ep_nx     = rx_endpoint;
                        in_toggle_nx = in_tog[rx_endpoint];
                        in_start_nx  = 1'b1;
                        state_nx     = IN_DATA;
                    end
                end
            end

            OUT_DATA: begin
                if (token_any || timed_out) begin
                    out_discard_nx = 1'b1;
                    state_nx       = IDLE;
                end else if (rx_data_end) begin
                    state_nx = IDLE;
                    if (rx_data_error) begin
                        out_discard_nx = 1'b1;
                    end else if (stall_w[out_ep]) begin
                        tx_stall_nx    = 1'b1;
                        out_discard_nx = 1'b1;
                    end else if (!out_rdy_w[out_ep]) begin
                        tx_nack_nx     = 1'b1;
                        out_discard_nx = 1'b1;
                    end else if (rx_data_type != {out_tog[out_ep], 1'b0}) begin
                        // Host missed our previous ACK and resent: ACK again
                        // but keep only the first copy.
                        tx_ack_nx      = 1'b1;
                        out_discard_nx = 1'b1;
                    end else begin
                        tx_ack_nx           = 1'b1;
                        out_commit_nx       = 1'b1;
                        out_tog_nx[out_ep]  = ~out_tog[out_ep];
                    end
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end

            SETUP_DATA: begin
                if (token_any || timed_out) begin
                    out_discard_nx = 1'b1;
                    state_nx       = IDLE;
                end else if (rx_data_end) begin
                    state_nx = IDLE;
                    if (rx_data_error || (rx_data_type != 2'b00)) begin
                        out_discard_nx = 1'b1;
                    end else begin
                        // SETUP always resynchronises both directions so the
                        // following data/status stage starts with DATA1.
                        tx_ack_nx          = 1'b1;
                        out_commit_nx      = 1'b1;
                        setup_seen_nx      = 1'b1;
                        out_tog_nx[out_ep] = 1'b1;
                        in_tog_nx[out_ep]  = 1'b1;
                    end
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end

            IN_DATA: begin
                if (in_done) begin
                    state_nx = IN_WAIT_ACK;
                end
            end

            IN_WAIT_ACK: begin
                if (token_any || timed_out) begin
                    in_timeout_nx = 1'b1;
                    state_nx      = IDLE;
                end else if (rx_ack) begin
                    in_acked_nx      = 1'b1;
                    in_tog_nx[in_ep] = ~in_tog[in_ep];
                    state_nx         = IDLE;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end

            default: state_nx = IDLE;
        endcase

        // Stays high through the response cycle that follows the data phase.
        out_active_nx = (state_nx == OUT_DATA) || (state_nx == SETUP_DATA) ||
                        (state == OUT_DATA) || (state == SETUP_DATA);
    end

    // State, toggles and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            out_tog     <= '0;
            in_tog      <= '0;
            out_ep      <= '0;
            in_ep       <= '0;
            in_toggle   <= 1'b0;
            out_active  <= 1'b0;
            tx_ack      <= 1'b0;
            tx_nack     <= 1'b0;
            tx_stall    <= 1'b0;
            out_commit  <= 1'b0;
            out_discard <= 1'b0;
            setup_seen  <= 1'b0;
            in_start    <= 1'b0;
            in_acked    <= 1'b0;
            in_timeout  <= 1'b0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            out_tog     <= out_tog_nx;
            in_tog      <= in_tog_nx;
            out_ep      <= out_ep_nx;
            in_ep       <= in_ep_nx;
            in_toggle   <= in_toggle_nx;
            out_active  <= out_active_nx;
            tx_ack      <= tx_ack_nx;
            tx_nack     <= tx_nack_nx;
            tx_stall    <= tx_stall_nx;
            out_commit  <= out_commit_nx;
            out_discard <= out_discard_nx;
            setup_seen  <= setup_seen_nx;
            in_start    <= in_start_nx;
            in_acked    <= in_acked_nx;
            in_timeout  <= in_timeout_nx;
        end
    end

endmodule

// File: tb/tb_usb_xfer_ctrl.sv
// tb_usb_xfer_ctrl
// Directed self-checking bench for usb_xfer_ctrl (NUM_EP=4, HS_TIMEOUT=800,
// device address 5). Inputs are driven 1 time unit after the rising edge and
// outputs are sampled at the same point after the next edge, so each check
// sees the registered response to the strobe driven just before.

module tb_usb_xfer_ctrl;

    localparam int NUM_EP     = 4;
    localparam int HS_TIMEOUT = 800;

    // Pulse vector order:
    // {tx_ack, tx_nack, tx_stall, out_commit, out_discard, setup_seen,
    //  in_start, in_acked, in_timeout}
    localparam logic [8:0] P_NONE       = 9'b000_000_000;
    localparam logic [8:0] P_ACK_COMMIT = 9'b100_100_000;
    localparam logic [8:0] P_ACK_DISC   = 9'b100_010_000;
    localparam logic [8:0] P_NAK_DISC   = 9'b010_010_000;
    localparam logic [8:0] P_STALL_DISC = 9'b001_010_000;
    localparam logic [8:0] P_DISC       = 9'b000_010_000;
    localparam logic [8:0] P_SETUP_OK   = 9'b100_101_000;
    localparam logic [8:0] P_IN_START   = 9'b000_000_100;
    localparam logic [8:0] P_IN_ACKED   = 9'b000_000_010;
    localparam logic [8:0] P_IN_TO      = 9'b000_000_001;
    localparam logic [8:0] P_NAK        = 9'b010_000_000;
    localparam logic [8:0] P_STALL      = 9'b001_000_000;

    localparam int K_OUT   = 0;
    localparam int K_IN    = 1;
    localparam int K_SETUP = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [6:0]        dev_addr;
    logic              rx_in_token, rx_out_token, rx_setup_token;
    logic [6:0]        rx_addr;
    logic [3:0]        rx_endpoint;
    logic              rx_ack;
    logic [1:0]        rx_data_type;
    logic              rx_data_end, rx_data_error;
    logic [NUM_EP-1:0] ep_out_ready, ep_in_ready, ep_stall;
    logic              tx_ack, tx_nack, tx_stall;
    logic [3:0]        out_ep;
    logic              out_active, out_commit, out_discard, setup_seen;
    logic [3:0]        in_ep;
    logic              in_start, in_toggle, in_done, in_acked, in_timeout;

    int n_tests = 0;
    int n_fail  = 0;

    usb_xfer_ctrl #(.NUM_EP(NUM_EP), .HS_TIMEOUT(HS_TIMEOUT)) dut (
        .clk(clk), .rst(rst), .dev_addr(dev_addr),
        .rx_in_token(rx_in_token), .rx_out_token(rx_out_token),
        .rx_setup_token(rx_setup_token), .rx_addr(rx_addr),
        .rx_endpoint(rx_endpoint), .rx_ack(rx_ack),
        .rx_data_type(rx_data_type), .rx_data_end(rx_data_end),
        .rx_data_error(rx_data_error), .ep_out_ready(ep_out_ready),
        .ep_in_ready(ep_in_ready), .ep_stall(ep_stall),
        .tx_ack(tx_ack), .tx_nack(tx_nack), .tx_stall(tx_stall),
        .out_ep(out_ep), .out_active(out_active), .out_commit(out_commit),
        .out_discard(out_discard), .setup_seen(setup_seen),
        .in_ep(in_ep), .in_start(in_start), .in_toggle(in_toggle),
        .in_done(in_done), .in_acked(in_acked), .in_timeout(in_timeout)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] pv();
        return {tx_ack, tx_nack, tx_stall, out_commit, out_discard,
                setup_seen, in_start, in_acked, in_timeout};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic token(input int kind, input logic [6:0] a, input logic [3:0] e);
        rx_addr     = a;
        rx_endpoint = e;
        rx_out_token   = (kind == K_OUT);
        rx_in_token    = (kind == K_IN);
        rx_setup_token = (kind == K_SETUP);
        tick();
        rx_out_token   = 1'b0;
        rx_in_token    = 1'b0;
        rx_setup_token = 1'b0;
    endtask

    task automatic data(input logic [1:0] t, input logic err);
        rx_data_type  = t;
        rx_data_error = err;
        rx_data_end   = 1'b1;
        tick();
        rx_data_end   = 1'b0;
        rx_data_error = 1'b0;
    endtask

    task automatic done_strobe();
        in_done = 1'b1;
        tick();
        in_done = 1'b0;
    endtask

    task automatic ack_strobe();
        rx_ack = 1'b1;
        tick();
        rx_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        n_tests++;
        if (pv() !== P_NONE || out_active !== 1'b0 || out_ep !== 4'd0 ||
            in_ep !== 4'd0 || in_toggle !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_outputs: got pulses %b act %b oep %0d iep %0d tog %b, expected all 0",
                     pv(), out_active, out_ep, in_ep, in_toggle);
        end
        tick();
        n_tests++;
        if (pv() !== P_NONE) begin
            n_fail++;
            $display("[TB] FAIL reset_idle: got %b, expected %b", pv(), P_NONE);
        end
    endtask

    task automatic test_out();
        token(K_OUT, 7'd5, 4'd1);
        n_tests++;
        if (pv() !== P_NONE || out_active !== 1'b1 || out_ep !== 4'd1) begin
            n_fail++;
            $display("[TB] FAIL out_token: got pulses %b act %b ep %0d, expected %b 1 1",
                     pv(), out_active, out_ep, P_NONE);
        end
        data(2'b00, 1'b0);
        n_tests++;
        if (pv() !== P_ACK_COMMIT || out_active !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL out_data0_commit: got %b act %b, expected %b act 1",
                     pv(), out_active, P_ACK_COMMIT);
        end
        tick();
        n_tests++;
        if (pv() !== P_NONE || out_active !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL out_after: got %b act %b, expected %b act 0",
                     pv(), out_active, P_NONE);
        end
        token(K_OUT, 7'd5, 4'd1);
        data(2'b00, 1'b0);
        n_tests++;
        if (pv() !== P_ACK_DISC) begin
            n_fail++;
            $display("[TB] FAIL out_duplicate: got %b, expected %b", pv(), P_ACK_DISC);
        end
        tick();
    endtask

    task automatic test_out_errors();
        ep_out_ready = 4'b1101;
        token(K_OUT, 7'd5, 4'd1);
        data(2'b10, 1'b0);
        n_tests++;
        if (pv() !== P_NAK_DISC) begin
            n_fail++;
            $display("[TB] FAIL out_not_ready: got %b, expected %b", pv(), P_NAK_DISC);
        end
        ep_out_ready = 4'b1111;
        ep_stall     = 4'b0010;
        token(K_OUT, 7'd5, 4'd1);
        data(2'b10, 1'b0);
        n_tests++;
        if (pv() !== P_STALL_DISC) begin
            n_fail++;
            $display("[TB] FAIL out_stall: got %b, expected %b", pv(), P_STALL_DISC);
        end
        ep_stall = 4'b0000;
        token(K_OUT, 7'd5, 4'd1);
        data(2'b10, 1'b1);
        n_tests++;
        if (pv() !== P_DISC) begin
            n_fail++;
            $display("[TB] FAIL out_crc_error: got %b, expected %b", pv(), P_DISC);
        end
        // Toggle of ep 1 is DATA1 now; a clean DATA1 must be committed.
        token(K_OUT, 7'd5, 4'd1);
        data(2'b10, 1'b0);
        n_tests++;
        if (pv() !== P_ACK_COMMIT) begin
            n_fail++;
            $display("[TB] FAIL out_data1_commit: got %b, expected %b", pv(), P_ACK_COMMIT);
        end
        tick();
    endtask

    task automatic test_in();
        token(K_IN, 7'd5, 4'd2);
        n_tests++;
        if (pv() !== P_IN_START || in_ep !== 4'd2 || in_toggle !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL in_grant0: got %b ep %0d tog %b, expected %b ep 2 tog 0",
                     pv(), in_ep, in_toggle, P_IN_START);
        end
        done_strobe();
        ack_strobe();
        n_tests++;
        if (pv() !== P_IN_ACKED) begin
            n_fail++;
            $display("[TB] FAIL in_acked: got %b, expected %b", pv(), P_IN_ACKED);
        end
        token(K_IN, 7'd5, 4'd2);
        n_tests++;
        if (pv() !== P_IN_START || in_toggle !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL in_grant1: got %b tog %b, expected %b tog 1",
                     pv(), in_toggle, P_IN_START);
        end
        done_strobe();
        ack_strobe();
        ep_in_ready = 4'b1011;
        token(K_IN, 7'd5, 4'd2);
        n_tests++;
        if (pv() !== P_NAK) begin
            n_fail++;
            $display("[TB] FAIL in_nak: got %b, expected %b", pv(), P_NAK);
        end
        ep_in_ready = 4'b1111;
        ep_stall    = 4'b0100;
        token(K_IN, 7'd5, 4'd2);
        n_tests++;
        if (pv() !== P_STALL) begin
            n_fail++;
            $display("[TB] FAIL in_stall: got %b, expected %b", pv(), P_STALL);
        end
        ep_stall = 4'b0000;
        tick();
    endtask

    task automatic test_in_timeout();
        int k;
        logic [8:0] seen;
        k    = 0;
        seen = P_NONE;
        token(K_IN, 7'd5, 4'd2);
        done_strobe();
        for (int i = 1; i <= HS_TIMEOUT + 100; i++) begin
            tick();
            if (pv() !== P_NONE) begin
                k    = i;
                seen = pv();
                break;
            end
        end
        n_tests++;
        if (k != HS_TIMEOUT || seen !== P_IN_TO) begin
            n_fail++;
            $display("[TB] FAIL in_timeout_cycle: got %b after %0d cycles, expected %b after %0d",
                     seen, k, P_IN_TO, HS_TIMEOUT);
        end
        token(K_IN, 7'd5, 4'd2);
        n_tests++;
        if (pv() !== P_IN_START || in_toggle !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL in_retry_toggle: got %b tog %b, expected %b tog 0",
                     pv(), in_toggle, P_IN_START);
        end
        done_strobe();
        ack_strobe();
        tick();
    endtask

    task automatic test_setup();
        token(K_SETUP, 7'd5, 4'd0);
        n_tests++;
        if (out_active !== 1'b1 || out_ep !== 4'd0) begin
            n_fail++;
            $display("[TB] FAIL setup_token: got act %b ep %0d, expected act 1 ep 0",
                     out_active, out_ep);
        end
        data(2'b00, 1'b0);
        n_tests++;
        if (pv() !== P_SETUP_OK) begin
            n_fail++;
            $display("[TB] FAIL setup_ok: got %b, expected %b", pv(), P_SETUP_OK);
        end
        token(K_IN, 7'd5, 4'd0);
        n_tests++;
        if (pv() !== P_IN_START || in_toggle !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL setup_in_toggle: got %b tog %b, expected %b tog 1",
                     pv(), in_toggle, P_IN_START);
        end
        done_strobe();
        ack_strobe();
        token(K_OUT, 7'd5, 4'd0);
        data(2'b10, 1'b0);
        n_tests++;
        if (pv() !== P_ACK_COMMIT) begin
            n_fail++;
            $display("[TB] FAIL setup_out_toggle: got %b, expected %b", pv(), P_ACK_COMMIT);
        end
        token(K_SETUP, 7'd5, 4'd0);
        data(2'b10, 1'b0);
        n_tests++;
        if (pv() !== P_DISC) begin
            n_fail++;
            $display("[TB] FAIL setup_data1: got %b, expected %b", pv(), P_DISC);
        end
        tick();
    endtask

    task automatic test_ignored();
        token(K_OUT, 7'd6, 4'd1);
        n_tests++;
        if (pv() !== P_NONE || out_active !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL ignore_addr: got %b act %b, expected %b act 0",
                     pv(), out_active, P_NONE);
        end
        token(K_IN, 7'd5, 4'd4);
        n_tests++;
        if (pv() !== P_NONE) begin
            n_fail++;
            $display("[TB] FAIL ignore_ep: got %b, expected %b", pv(), P_NONE);
        end
        data(2'b00, 1'b0);
        n_tests++;
        if (pv() !== P_NONE || out_active !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL ignore_idle_data: got %b act %b, expected %b act 0",
                     pv(), out_active, P_NONE);
        end
    endtask

    task automatic test_abort();
        token(K_OUT, 7'd5, 4'd3);
        // New token together with rx_data_end: the token aborts, nothing starts.
        rx_data_type = 2'b00;
        rx_data_end  = 1'b1;
        token(K_IN, 7'd5, 4'd3);
        rx_data_end  = 1'b0;
        n_tests++;
        if (pv() !== P_DISC) begin
            n_fail++;
            $display("[TB] FAIL abort_out: got %b, expected %b", pv(), P_DISC);
        end
        tick();
        n_tests++;
        if (pv() !== P_NONE || out_active !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL abort_dropped: got %b act %b, expected %b act 0",
                     pv(), out_active, P_NONE);
        end
        token(K_IN, 7'd5, 4'd3);
        done_strobe();
        rx_ack = 1'b1;
        token(K_OUT, 7'd5, 4'd3);
        rx_ack = 1'b0;
        n_tests++;
        if (pv() !== P_IN_TO) begin
            n_fail++;
            $display("[TB] FAIL abort_in_wait: got %b, expected %b", pv(), P_IN_TO);
        end
        token(K_IN, 7'd5, 4'd3);
        n_tests++;
        if (pv() !== P_IN_START || in_toggle !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL abort_in_toggle: got %b tog %b, expected %b tog 0",
                     pv(), in_toggle, P_IN_START);
        end
        done_strobe();
        ack_strobe();
        tick();
    endtask

    task automatic test_reset_mid();
        token(K_IN, 7'd5, 4'd1);
        done_strobe();
        ack_strobe();
        token(K_IN, 7'd5, 4'd1);
        n_tests++;
        if (in_toggle !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL rst_pre_toggle: got %b, expected 1", in_toggle);
        end
        done_strobe();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_tests++;
        if (pv() !== P_NONE || in_toggle !== 1'b0 || in_ep !== 4'd0 || out_active !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL rst_mid_outputs: got %b tog %b ep %0d act %b, expected all 0",
                     pv(), in_toggle, in_ep, out_active);
        end
        token(K_IN, 7'd5, 4'd1);
        n_tests++;
        if (pv() !== P_IN_START || in_toggle !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL rst_mid_toggle: got %b tog %b, expected %b tog 0",
                     pv(), in_toggle, P_IN_START);
        end
        done_strobe();
        ack_strobe();
    endtask

    initial begin
        rst            = 1'b1;
        dev_addr       = 7'd5;
        rx_in_token    = 1'b0;
        rx_out_token   = 1'b0;
        rx_setup_token = 1'b0;
        rx_addr        = 7'd0;
        rx_endpoint    = 4'd0;
        rx_ack         = 1'b0;
        rx_data_type   = 2'b00;
        rx_data_end    = 1'b0;
        rx_data_error  = 1'b0;
        ep_out_ready   = 4'b1111;
        ep_in_ready    = 4'b1111;
        ep_stall       = 4'b0000;
        in_done        = 1'b0;

        test_reset();
        test_out();
        test_out_errors();
        test_in();
        test_in_timeout();
        test_setup();
        test_ignored();
        test_abort();
        test_reset_mid();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
